mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the processor's single memory port. Instruction fetch and data load/store each request the memory. The block grants one of them, drives the memory for one access, waits the fixed memory latency and returns a single-cycle response to the winner. It sits between the multicycle control/datapath and the unified memory, and turns two request/grant ports into one timed memory access stream.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that serialises instruction fetch and
// data load/store onto one fixed-latency memory port, one access at a time.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,

    output logic        busy,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    owner_t      owner;
    owner_t      last_owner;
    logic        we_q;
    logic [3:0]  cnt;
    logic [63:0] resp_q;
    logic        grant_if;
    logic        grant_d;

    // A tie goes to whichever port did not win last time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE && !reset) begin
            if (if_req && d_req) begin
                grant_d  = (last_owner == OWN_IF);
                grant_if = (last_owner == OWN_D);
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments only.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_if || grant_d) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The memory strobe and request latches are loaded on the grant edge so
    // they are already presented during ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            we_q       <= 1'b0;
            cnt        <= 4'd0;
            resp_q     <= 64'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 64'd0;
            mem_wdata  <= 64'd0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        owner      <= grant_d ? OWN_D : OWN_IF;
                        last_owner <= grant_d ? OWN_D : OWN_IF;
                        we_q       <= grant_d & d_we;
                        mem_en     <= 1'b1;
                        mem_we     <= grant_d & d_we;
                        mem_addr   <= grant_d ? d_addr : if_addr;
                        mem_wdata  <= grant_d ? d_wdata : 64'd0;
                    end
                end
                ISSUE: cnt <= CNT_INIT;
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) resp_q <= mem_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        busy      = (state != IDLE);
        state_out = state;
        if_rvalid = (state == RESP) && (owner == OWN_IF);
        d_rvalid  = (state == RESP) && (owner == OWN_D);
    end

    // Both ports observe the one shared response register.
    assign if_rdata = resp_q;
    assign d_rdata  = resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level timing model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        reset;

    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    logic [1:0]  state_out;

    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [63:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [63:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [63:0] b_mem_addr, b_mem_wdata;
    logic [63:0] b_mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    logic [1:0]  b_state_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(LAT_A)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_out(state_out)
    );

    mem_port_arbiter #(.MEM_LAT(LAT_B)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .state_out(b_state_out)
    );

    function automatic logic [63:0] mem_init(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_A5A5, ~a[31:0]};
    endfunction

    // Memory responders: read data is valid only during the cycle in which
    // the arbiter must sample it, garbage otherwise.
    logic [63:0] mem_a [logic [63:0]];
    logic [63:0] mem_b [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] pend_a, pend_b;
    int          left_a = -1;
    int          left_b = -1;

    always @(negedge clk) begin
        if (left_a >= 0) left_a--;
        if (mem_en) begin
            if (mem_we) mem_a[mem_addr] = mem_wdata;
            else begin
                pend_a = mem_a.exists(mem_addr) ? mem_a[mem_addr] : mem_init(mem_addr);
                left_a = LAT_A;
            end
        end
        mem_rdata = (left_a == 0) ? pend_a : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(negedge clk) begin
        if (left_b >= 0) left_b--;
        if (b_mem_en) begin
            if (b_mem_we) mem_b[b_mem_addr] = b_mem_wdata;
            else begin
                pend_b = mem_b.exists(b_mem_addr) ? mem_b[b_mem_addr] : mem_init(b_mem_addr);
                left_b = LAT_B;
            end
        end
        b_mem_rdata = (left_b == 0) ? pend_b : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; b_if_req = 1'b1; b_d_req = 1'b1;
        #1;
        total++;
        if ({if_gnt, d_gnt, b_if_gnt, b_d_gnt} !== 4'b0)
            $display("FAIL reset_gnt: got %b expected 0000", {if_gnt, d_gnt, b_if_gnt, b_d_gnt});
        else passed++;
        tick();
        #1;
        total++;
        if ({state_out, busy, mem_en, mem_we, if_rvalid, d_rvalid, if_gnt, d_gnt} !== 9'b0)
            $display("FAIL reset_ctrl_a: got %b expected 0",
                     {state_out, busy, mem_en, mem_we, if_rvalid, d_rvalid, if_gnt, d_gnt});
        else passed++;
        total++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 256'b0)
            $display("FAIL reset_data_a: addr %h wdata %h rdata %h/%h expected all 0",
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        else passed++;
        total++;
        if ({b_state_out, b_busy, b_mem_en, b_mem_we, b_if_rvalid, b_d_rvalid, b_if_gnt, b_d_gnt} !== 9'b0 ||
            {b_mem_addr, b_mem_wdata, b_if_rdata, b_d_rdata} !== 256'b0)
            $display("FAIL reset_b: state %0d busy %b en %b expected all outputs 0",
                     b_state_out, b_busy, b_mem_en);
        else passed++;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; b_if_req = 1'b0; b_d_req = 1'b0;
    endtask

    task automatic test_single_fetch_lat1();
        logic [6:0] exp_v;
        mem_b[64'h40] = 64'h0000_0000_00A0_0093;
        tick();
        b_if_req = 1'b1; b_if_addr = 64'h40;
        #1;
        total++;
        if ({b_if_gnt, b_d_gnt} !== 2'b10)
            $display("FAIL fetch1_gnt: got %b expected 10", {b_if_gnt, b_d_gnt});
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            b_if_req = 1'b0; b_if_addr = 64'hFFF0;
            #1;
            case (k)
                1:       exp_v = 7'b01_1_1_0_0_0;
                2:       exp_v = 7'b10_1_0_0_0_0;
                3:       exp_v = 7'b11_1_0_1_0_0;
                default: exp_v = 7'b00_0_0_0_0_0;
            endcase
            total++;
            if ({b_state_out, b_busy, b_mem_en, b_if_rvalid, b_d_rvalid, b_if_gnt} !== exp_v)
                $display("FAIL fetch1_cycle%0d: got %b expected %b", k,
                         {b_state_out, b_busy, b_mem_en, b_if_rvalid, b_d_rvalid, b_if_gnt}, exp_v);
            else passed++;
            if (k == 1) begin
                total++;
                if (b_mem_addr !== 64'h40)
                    $display("FAIL fetch1_addr: got %h expected 40", b_mem_addr);
                else passed++;
            end
            if (k == 3) begin
                total++;
                if (b_if_rdata !== 64'h00A0_0093)
                    $display("FAIL fetch1_rdata: got %h expected 00a00093", b_if_rdata);
                else passed++;
            end
        end
    endtask

    task automatic test_store();
        logic [63:0] prior;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        #1;
        total++;
        if (d_gnt !== 1'b1) $display("FAIL store_preload_gnt: got %b expected 1", d_gnt);
        else passed++;
        for (int k = 1; k <= 5; k++) begin
            tick();
            d_req = 1'b0;
            #1;
        end
        prior = mem_init(64'h100);
        total++;
        if ({d_rvalid, d_rdata} !== {1'b1, prior})
            $display("FAIL store_preload_data: rvalid %b data %h expected 1 %h", d_rvalid, d_rdata, prior);
        else passed++;
        tick();
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF;
        #1;
        total++;
        if (d_gnt !== 1'b1) $display("FAIL store_gnt: got %b expected 1", d_gnt);
        else passed++;
        for (int k = 1; k <= 6; k++) begin
            tick();
            d_req = 1'b0; d_we = 1'b0; d_addr = 64'h0; d_wdata = 64'h1234;
            #1;
            total++;
            if ({mem_en, mem_we, d_rvalid, if_rvalid} !== {k == 1, k == 1, k == 5, 1'b0})
                $display("FAIL store_cycle%0d: en/we/drv/irv %b expected %b", k,
                         {mem_en, mem_we, d_rvalid, if_rvalid}, {k == 1, k == 1, k == 5, 1'b0});
            else passed++;
            total++;
            if (d_rdata !== prior)
                $display("FAIL store_rdata_kept%0d: got %h expected %h", k, d_rdata, prior);
            else passed++;
            if (k == 1) begin
                total++;
                if ({mem_addr, mem_wdata} !== {64'h100, 64'hDEAD_BEEF})
                    $display("FAIL store_bus: addr %h wdata %h expected 100 deadbeef", mem_addr, mem_wdata);
                else passed++;
            end
        end
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        for (int k = 1; k <= 5; k++) begin
            tick();
            d_req = 1'b0;
            #1;
        end
        total++;
        if ({d_rvalid, d_rdata} !== {1'b1, 64'hDEAD_BEEF})
            $display("FAIL store_readback: rvalid %b data %h expected 1 deadbeef", d_rvalid, d_rdata);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back_tie();
        logic gslot, dturn, rslot;
        logic [63:0] exp_data;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            tick();
            if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 64'h2000; d_addr = 64'h2008;
            #1;
            gslot = (c % (LAT_A + 3) == 0);
            rslot = (c % (LAT_A + 3) == LAT_A + 2);
            dturn = ((c / (LAT_A + 3)) % 2 == 0);
            total++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !==
                {gslot && !dturn, gslot && dturn, rslot && !dturn, rslot && dturn})
                $display("FAIL tie_cycle%0d: gnt/rvalid %b expected %b", c,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid},
                         {gslot && !dturn, gslot && dturn, rslot && !dturn, rslot && dturn});
            else passed++;
            if (rslot) begin
                exp_data = mem_init(dturn ? 64'h2008 : 64'h2000);
                total++;
                if (d_rdata !== exp_data)
                    $display("FAIL tie_data%0d: got %h expected %h", c, d_rdata, exp_data);
                else passed++;
            end
        end
        tick();
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3000;
        #1;
        total++;
        if (d_gnt !== 1'b1) $display("FAIL abort_gnt: got %b expected 1", d_gnt);
        else passed++;
        tick(); d_req = 1'b0;
        tick();
        #1;
        total++;
        if (state_out !== 2'd2) $display("FAIL abort_in_wait: state %0d expected 2", state_out);
        else passed++;
        tick();
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1;
        tick();
        #1;
        total++;
        if ({state_out, busy, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 8'b0 || d_rdata !== 64'd0)
            $display("FAIL abort_reset_state: ctrl %b rdata %h expected 0 0",
                     {state_out, busy, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid}, d_rdata);
        else passed++;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0100)
            $display("FAIL abort_first_tie: gnt/rvalid %b expected 0100", {if_gnt, d_gnt, if_rvalid, d_rvalid});
        else passed++;
        for (int k = 1; k <= LAT_A + 2; k++) begin
            tick();
            if_req = 1'b0; d_req = 1'b0;
            #1;
            total++;
            if ({if_rvalid, d_rvalid} !== {1'b0, k == LAT_A + 2})
                $display("FAIL abort_rvalid%0d: got %b expected %b", k, {if_rvalid, d_rvalid},
                         {1'b0, k == LAT_A + 2});
            else passed++;
        end
        total++;
        if (d_rdata !== mem_init(64'h3000))
            $display("FAIL abort_new_data: got %h expected %h", d_rdata, mem_init(64'h3000));
        else passed++;
        tick();
    endtask

    task automatic test_req_change_after_grant();
        int pulses;
        logic [63:0] got;
        pulses = 0;
        got = 64'd0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
        #1;
        total++;
        if (d_gnt !== 1'b1) $display("FAIL chg_gnt: got %b expected 1", d_gnt);
        else passed++;
        tick();
        d_addr = 64'h300; d_req = 1'b0; d_we = 1'b1;
        #1;
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 64'h200})
            $display("FAIL chg_addr: en %b we %b addr %h expected 1 0 200", mem_en, mem_we, mem_addr);
        else passed++;
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (d_rvalid) begin
                pulses++;
                got = d_rdata;
            end
        end
        total++;
        if (pulses != 1 || got !== mem_init(64'h200))
            $display("FAIL chg_resp: pulses %0d data %h expected 1 %h", pulses, got, mem_init(64'h200));
        else passed++;
        d_we = 1'b0;
    endtask

    task automatic test_req_during_busy();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400;
        #1;
        total++;
        if (d_gnt !== 1'b1) $display("FAIL busy_first_gnt: got %b expected 1", d_gnt);
        else passed++;
        for (int k = 1; k <= LAT_A + 2; k++) begin
            tick();
            d_req = 1'b0; if_req = 1'b1; if_addr = 64'h500;
            #1;
            total++;
            if ({if_gnt, d_gnt, busy} !== 3'b001)
                $display("FAIL busy_gnt_low%0d: gnt/busy %b expected 001", k, {if_gnt, d_gnt, busy});
            else passed++;
        end
        tick();
        #1;
        total++;
        if ({if_gnt, state_out} !== 3'b100)
            $display("FAIL busy_late_gnt: gnt/state %b expected 100", {if_gnt, state_out});
        else passed++;
        tick();
        if_req = 1'b0;
        #1;
        total++;
        if ({if_gnt, state_out} !== 3'b001)
            $display("FAIL busy_gnt_once: gnt/state %b expected 001", {if_gnt, state_out});
        else passed++;
        for (int k = 1; k <= LAT_A + 1; k++) tick();
        total++;
        if ({if_rvalid, if_rdata} !== {1'b1, mem_init(64'h500)})
            $display("FAIL busy_resp: rvalid %b data %h expected 1 %h", if_rvalid, if_rdata, mem_init(64'h500));
        else passed++;
        tick();
    endtask

    // Transaction model: an access granted at cycle g occupies cycles
    // g+1 .. g+LAT+2, and the port is free again from g+LAT+3.
    task automatic test_random(input int ncycles);
        int next_free, g_c, rel, exp_state;
        logic last_d, win_d, m_owner, m_we, prev_ig, prev_dg;
        logic exp_ig, exp_dg, exp_en, exp_busy;
        logic [63:0] m_addr, m_wdata, m_data, resp_val;
        logic [8:0] exp_v;
        do_reset();
        next_free = 0; g_c = -100; last_d = 1'b0; resp_val = 64'd0;
        m_owner = 1'b0; m_we = 1'b0; m_addr = 64'd0; m_wdata = 64'd0; m_data = 64'd0;
        prev_ig = 1'b0; prev_dg = 1'b0;
        for (int c = 0; c < ncycles; c++) begin
            tick();
            if (prev_ig) if_req = ($urandom_range(1) == 1);
            else if (!if_req) if_req = ($urandom_range(3) == 0);
            else if ($urandom_range(15) == 0) if_req = 1'b0;
            if (prev_dg) d_req = ($urandom_range(1) == 1);
            else if (!d_req) d_req = ($urandom_range(3) == 0);
            else if ($urandom_range(15) == 0) d_req = 1'b0;
            if_addr = 64'h1000 + 64'(8 * $urandom_range(7));
            d_addr  = 64'h1000 + 64'(8 * $urandom_range(7));
            d_we    = 1'($urandom_range(1));
            d_wdata = {$urandom, $urandom};
            #1;
            exp_ig = 1'b0; exp_dg = 1'b0;
            if (c >= next_free && (if_req || d_req)) begin
                win_d = (if_req && d_req) ? !last_d : d_req;
                exp_ig = !win_d; exp_dg = win_d;
                g_c = c; next_free = c + LAT_A + 3; last_d = win_d; m_owner = win_d;
                m_we = win_d && d_we;
                m_addr = win_d ? d_addr : if_addr;
                m_wdata = d_wdata;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else m_data = ref_mem.exists(m_addr) ? ref_mem[m_addr] : mem_init(m_addr);
            end
            prev_ig = exp_ig; prev_dg = exp_dg;
            rel = c - g_c;
            exp_state = (rel == 1) ? 1 : (rel >= 2 && rel <= LAT_A + 1) ? 2 : (rel == LAT_A + 2) ? 3 : 0;
            exp_busy = (exp_state != 0);
            exp_en = (rel == 1);
            if (rel == LAT_A + 2 && !m_we) resp_val = m_data;
            exp_v = {exp_ig, exp_dg, rel == LAT_A + 2 && !m_owner, rel == LAT_A + 2 && m_owner,
                     exp_busy, 2'(exp_state), exp_en, exp_en && m_we};
            total++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid, busy, state_out, mem_en, mem_we} !== exp_v)
                $display("FAIL rand_ctrl c%0d: got %b expected %b", c,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid, busy, state_out, mem_en, mem_we}, exp_v);
            else passed++;
            total++;
            if (if_rdata !== resp_val || d_rdata !== resp_val)
                $display("FAIL rand_rdata c%0d: got %h/%h expected %h", c, if_rdata, d_rdata, resp_val);
            else passed++;
            if (exp_en) begin
                total++;
                if (mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata))
                    $display("FAIL rand_bus c%0d: addr %h wdata %h expected %h %h", c,
                             mem_addr, mem_wdata, m_addr, m_wdata);
                else passed++;
            end
        end
        tick();
        if_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < LAT_A + 3; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = 64'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0;
        b_if_req = 1'b0; b_if_addr = 64'd0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 64'd0; b_d_wdata = 64'd0;
        test_reset();
        test_single_fetch_lat1();
        test_store();
        test_back_to_back_tie();
        test_reset_mid_access();
        test_req_change_after_grant();
        test_req_during_busy();
        test_random(600);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
